// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - Shared fetch FSM state enum, base opcode constants and PC helpers.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } fetch_state_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;

    localparam logic [63:0] INSTR_BYTES = 64'd4;

    // Instructions are 4-byte aligned; low address bits of a target are dropped.
    function automatic logic [63:0] align_pc(input logic [63:0] addr);
        return addr & ~64'h3;
    endfunction

endpackage

// File: rtl/opcode_check.sv
// rtl/opcode_check.sv - Flags whether a 7-bit major opcode belongs to the supported set.
module opcode_check
    import instr_fetch_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       legal
);

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OPC_LOAD,
            OPC_OP_IMM,
            OPC_JALR,
            OPC_OP_IMM_32,
            OPC_STORE,
            OPC_OP,
            OPC_OP_32,
            OPC_BRANCH,
            OPC_JAL,
            OPC_AUIPC,
            OPC_LUI:  legal = 1'b1;
            default:  legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - Single-outstanding instruction fetch FSM with redirect squash.
// FETCH_OPCODE_CHECK_EN enables the registered o_instr_illegal opcode check.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_mem_req_valid,
    input  logic        i_mem_req_ready,
    output logic [63:0] o_mem_addr,
    input  logic        i_mem_rsp_valid,
    input  logic [31:0] i_mem_rsp_data,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_instr,
    output logic [63:0] o_pc,
    input  logic        i_redirect,
    input  logic [63:0] i_redirect_pc,
    output logic        o_instr_illegal
);

    fetch_state_e state;
    fetch_state_e state_d;
    logic [63:0]  pc;
    logic [63:0]  pc_d;
    logic         squash;
    logic         squash_d;
    logic         buf_load;
    logic         buf_clear;
    logic [63:0]  redirect_target;

    logic [31:0]  instr_q;
    logic [63:0]  pc_q;
    logic         valid_q;

    assign redirect_target = align_pc(i_redirect_pc);
    assign o_mem_req_valid = (state == ST_REQ);
    assign o_mem_addr      = pc;
    assign o_instr_valid   = valid_q;
    assign o_instr         = instr_q;
    assign o_pc            = pc_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            pc     <= RESET_PC;
            squash <= 1'b0;
        end else begin
            state  <= state_d;
            pc     <= pc_d;
            squash <= squash_d;
        end
    end

    always_comb begin
        state_d   = state;
        pc_d      = pc;
        squash_d  = squash;
        buf_load  = 1'b0;
        buf_clear = 1'b0;

        case (state)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                // A redirect racing the handshake leaves a stale read in flight.
                if (i_mem_req_ready) begin
                    state_d  = ST_WAIT;
                    squash_d = i_redirect;
                end
            end
            ST_WAIT: begin
                if (i_mem_rsp_valid) begin
                    squash_d = 1'b0;
                    if (i_redirect || squash) begin
                        state_d = ST_REQ;
                    end else begin
                        buf_load = 1'b1;
                        pc_d     = pc + INSTR_BYTES;
                        state_d  = ST_HOLD;
                    end
                end else if (i_redirect) begin
                    squash_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (i_instr_ready) begin
                    buf_clear = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Redirect wins over everything; WAIT keeps its squash-based routing above.
        if (i_redirect) begin
            pc_d      = redirect_target;
            buf_clear = 1'b1;
            if (state == ST_HOLD) begin
                state_d = ST_REQ;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            pc_q    <= 64'h0;
        end else if (buf_load) begin
            valid_q <= 1'b1;
            instr_q <= i_mem_rsp_data;
            pc_q    <= pc;
        end else if (buf_clear) begin
            valid_q <= 1'b0;
        end
    end

`ifdef FETCH_OPCODE_CHECK_EN
    logic opcode_legal;
    logic illegal_q;

    opcode_check u_opcode_check (
        .opcode (i_mem_rsp_data[6:0]),
        .legal  (opcode_legal)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            illegal_q <= 1'b0;
        end else if (buf_load) begin
            illegal_q <= ~opcode_legal;
        end
    end

    assign o_instr_illegal = illegal_q;
`else
    assign o_instr_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - Scoreboard bench for instr_fetch: sequencing, stalls, redirects, reset.
module tb_instr_fetch;

    localparam logic [63:0] RESET_PC = 64'h0;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready;
    logic [63:0] o_mem_addr;
    logic        i_mem_rsp_valid;
    logic [31:0] i_mem_rsp_data;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic [31:0] o_instr;
    logic [63:0] o_pc;
    logic        i_redirect;
    logic [63:0] i_redirect_pc;
    logic        o_instr_illegal;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        illegal;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 i_clk = ~i_clk;

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .o_mem_req_valid (o_mem_req_valid),
        .i_mem_req_ready (i_mem_req_ready),
        .o_mem_addr      (o_mem_addr),
        .i_mem_rsp_valid (i_mem_rsp_valid),
        .i_mem_rsp_data  (i_mem_rsp_data),
        .o_instr_valid   (o_instr_valid),
        .i_instr_ready   (i_instr_ready),
        .o_instr         (o_instr),
        .o_pc            (o_pc),
        .i_redirect      (i_redirect),
        .i_redirect_pc   (i_redirect_pc),
        .o_instr_illegal (o_instr_illegal)
    );

    function automatic logic exp_illegal(input logic [31:0] w);
`ifdef FETCH_OPCODE_CHECK_EN
        case (w[6:0])
            7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h33,
            7'h3B, 7'h63, 7'h6F, 7'h17, 7'h37: return 1'b0;
            default:                           return 1'b1;
        endcase
`else
        return 1'b0;
`endif
    endfunction

    // Called at a negedge; returns at the negedge after the accepted handshake.
    task automatic handshake(output bit timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (o_mem_req_valid) begin
                i_mem_req_ready = 1'b1;
                @(negedge i_clk);
                i_mem_req_ready = 1'b0;
                timed_out = 1'b0;
                break;
            end
            @(negedge i_clk);
        end
    endtask

    task automatic respond(input logic [31:0] word, input bit expect_out);
        exp_t e;
        i_mem_rsp_valid = 1'b1;
        i_mem_rsp_data  = word;
        if (expect_out) begin
            e.pc = o_mem_addr;
            e.instr = word;
            e.illegal = exp_illegal(word);
            sb.push_back(e);
        end
        @(negedge i_clk);
        i_mem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_mem_req_ready = 1'b0;
        i_mem_rsp_valid = 1'b0;
        i_mem_rsp_data = 32'h0;
        i_instr_ready = 1'b0;
        i_redirect = 1'b0;
        i_redirect_pc = 64'h0;
        repeat (3) @(negedge i_clk);
        n_total++;
        if ({o_mem_req_valid, o_instr_valid, o_instr_illegal} !== 3'b000 || o_instr !== 32'h0 || o_pc !== 64'h0) begin
            $display("FAIL reset_outputs: req=%b vld=%b ill=%b instr=%h pc=%h, required all zero",
                     o_mem_req_valid, o_instr_valid, o_instr_illegal, o_instr, o_pc);
        end else n_pass++;
        n_total++;
        if (o_mem_addr !== RESET_PC) $display("FAIL reset_addr: got %h, required %h", o_mem_addr, RESET_PC);
        else n_pass++;
        i_rst = 1'b0;
        @(negedge i_clk);
        n_total++;
        if (o_mem_req_valid !== 1'b1 || o_mem_addr !== RESET_PC)
            $display("FAIL first_req: req=%b addr=%h, required 1 %h", o_mem_req_valid, o_mem_addr, RESET_PC);
        else n_pass++;
    endtask

    task automatic test_sequential();
        logic [63:0] exp_addr = RESET_PC;
        logic [31:0] rsp_word = 32'h0;
        bit          rsp_due = 1'b0;
        int          got = 0;
        exp_t        e;
        i_mem_req_ready = 1'b1;
        i_instr_ready   = 1'b1;
        for (int c = 0; c < 40 && got < 3; c++) begin
            if (o_instr_valid) begin
                n_total++;
                if (sb.size() == 0) $display("FAIL seq_unexpected: instr %h pc %h, required none", o_instr, o_pc);
                else begin
                    e = sb.pop_front();
                    if (o_instr !== e.instr || o_pc !== e.pc || o_instr_illegal !== e.illegal)
                        $display("FAIL seq_instr: got %h@%h ill=%b, required %h@%h ill=%b",
                                 o_instr, o_pc, o_instr_illegal, e.instr, e.pc, e.illegal);
                    else n_pass++;
                end
                got++;
            end
            i_mem_rsp_valid = rsp_due;
            i_mem_rsp_data  = rsp_word;
            rsp_due = 1'b0;
            if (o_mem_req_valid) begin
                n_total++;
                if (o_mem_addr !== exp_addr) $display("FAIL seq_addr: got %h, required %h", o_mem_addr, exp_addr);
                else n_pass++;
                rsp_word = {o_mem_addr[11:0], 20'h00013};
                e.pc = o_mem_addr;
                e.instr = rsp_word;
                e.illegal = exp_illegal(rsp_word);
                sb.push_back(e);
                rsp_due = 1'b1;
                exp_addr = exp_addr + 64'd4;
            end
            @(negedge i_clk);
        end
        i_mem_req_ready = 1'b0;
        i_instr_ready   = 1'b0;
        n_total++;
        if (got != 3) $display("FAIL seq_timeout: got %0d instrs, required 3", got);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            n_total++;
            if (o_mem_req_valid !== 1'b1 || o_mem_addr !== 64'hC)
                $display("FAIL req_stable: req=%b addr=%h, required 1 000000000000000c", o_mem_req_valid, o_mem_addr);
            else n_pass++;
            @(negedge i_clk);
        end
    endtask

    task automatic test_decode_stall();
        bit   to;
        exp_t e;
        handshake(to);
        n_total++;
        if (to) $display("FAIL stall_handshake: timed out, required request");
        else n_pass++;
        respond(32'h00500093, 1'b1);
        for (int c = 0; c < 5; c++) begin
            n_total++;
            if (o_instr_valid !== 1'b1 || o_instr !== 32'h00500093 || o_pc !== 64'hC || o_mem_req_valid !== 1'b0)
                $display("FAIL stall_hold: vld=%b instr=%h pc=%h req=%b, required 1 00500093 c 0",
                         o_instr_valid, o_instr, o_pc, o_mem_req_valid);
            else n_pass++;
            @(negedge i_clk);
        end
        i_instr_ready = 1'b1;
        n_total++;
        if (sb.size() == 0) $display("FAIL stall_sb: queue empty, required one entry");
        else begin
            e = sb.pop_front();
            if (o_instr !== e.instr || o_pc !== e.pc || o_instr_illegal !== e.illegal)
                $display("FAIL stall_instr: got %h@%h ill=%b, required %h@%h ill=%b",
                         o_instr, o_pc, o_instr_illegal, e.instr, e.pc, e.illegal);
            else n_pass++;
        end
        @(negedge i_clk);
        i_instr_ready = 1'b0;
        n_total++;
        if (o_instr_valid !== 1'b0 || o_mem_req_valid !== 1'b1 || o_mem_addr !== 64'h10)
            $display("FAIL stall_release: vld=%b req=%b addr=%h, required 0 1 10", o_instr_valid, o_mem_req_valid, o_mem_addr);
        else n_pass++;
    endtask

    task automatic test_redirect_in_wait();
        bit   to;
        exp_t e;
        handshake(to);
        i_redirect = 1'b1;
        i_redirect_pc = 64'h1002;
        @(negedge i_clk);
        i_redirect = 1'b0;
        n_total++;
        if (o_mem_req_valid !== 1'b0) $display("FAIL squash_wait: req=%b, required 0", o_mem_req_valid);
        else n_pass++;
        @(negedge i_clk);
        respond(32'hDEADBEEF, 1'b0);
        n_total++;
        if (o_instr_valid !== 1'b0 || o_mem_req_valid !== 1'b1 || o_mem_addr !== 64'h1000)
            $display("FAIL squash_drop: vld=%b req=%b addr=%h, required 0 1 1000", o_instr_valid, o_mem_req_valid, o_mem_addr);
        else n_pass++;
        handshake(to);
        respond(32'h00000013, 1'b1);
        n_total++;
        if (sb.size() == 0 || o_instr_valid !== 1'b1) $display("FAIL squash_after: vld=%b, required 1 with entry", o_instr_valid);
        else begin
            e = sb.pop_front();
            if (o_instr !== e.instr || o_pc !== e.pc || o_instr_illegal !== e.illegal)
                $display("FAIL squash_after_instr: got %h@%h ill=%b, required %h@%h ill=%b",
                         o_instr, o_pc, o_instr_illegal, e.instr, e.pc, e.illegal);
            else n_pass++;
        end
        i_instr_ready = 1'b1;
        @(negedge i_clk);
        i_instr_ready = 1'b0;
    endtask

    task automatic test_redirect_with_rsp();
        bit   to;
        exp_t e;
        handshake(to);
        i_redirect = 1'b1;
        i_redirect_pc = 64'h2000;
        respond(32'h11111111, 1'b0);
        i_redirect = 1'b0;
        n_total++;
        if (o_instr_valid !== 1'b0 || o_mem_req_valid !== 1'b1 || o_mem_addr !== 64'h2000)
            $display("FAIL coincident: vld=%b req=%b addr=%h, required 0 1 2000", o_instr_valid, o_mem_req_valid, o_mem_addr);
        else n_pass++;
        handshake(to);
        respond(32'h0000007F, 1'b1);
        n_total++;
        if (sb.size() == 0 || o_instr_valid !== 1'b1) $display("FAIL coincident_after: vld=%b, required 1 with entry", o_instr_valid);
        else begin
            e = sb.pop_front();
            if (o_instr !== e.instr || o_pc !== e.pc || o_instr_illegal !== e.illegal)
                $display("FAIL illegal_word: got %h@%h ill=%b, required %h@%h ill=%b",
                         o_instr, o_pc, o_instr_illegal, e.instr, e.pc, e.illegal);
            else n_pass++;
        end
    endtask

    task automatic test_redirect_in_hold();
        i_redirect = 1'b1;
        i_redirect_pc = 64'h3000;
        respond(32'h33333333, 1'b0);
        i_redirect = 1'b0;
        n_total++;
        if (o_instr_valid !== 1'b0 || o_mem_req_valid !== 1'b1 || o_mem_addr !== 64'h3000)
            $display("FAIL hold_redirect: vld=%b req=%b addr=%h, required 0 1 3000", o_instr_valid, o_mem_req_valid, o_mem_addr);
        else n_pass++;
        @(negedge i_clk);
        n_total++;
        if (o_instr_valid !== 1'b0) $display("FAIL hold_stray: vld=%b, required 0", o_instr_valid);
        else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        bit   to;
        exp_t e;
        handshake(to);
        i_rst = 1'b1;
        @(negedge i_clk);
        n_total++;
        if (o_mem_req_valid !== 1'b0 || o_instr_valid !== 1'b0 || o_instr !== 32'h0 || o_pc !== 64'h0)
            $display("FAIL midreset: req=%b vld=%b instr=%h pc=%h, required all zero", o_mem_req_valid, o_instr_valid, o_instr, o_pc);
        else n_pass++;
        i_rst = 1'b0;
        respond(32'h44444444, 1'b0);
        n_total++;
        if (o_instr_valid !== 1'b0 || o_mem_req_valid !== 1'b1 || o_mem_addr !== RESET_PC)
            $display("FAIL late_rsp: vld=%b req=%b addr=%h, required 0 1 %h", o_instr_valid, o_mem_req_valid, o_mem_addr, RESET_PC);
        else n_pass++;
        handshake(to);
        respond(32'h00A00113, 1'b1);
        n_total++;
        if (sb.size() == 0 || o_instr_valid !== 1'b1) $display("FAIL post_reset: vld=%b, required 1 with entry", o_instr_valid);
        else begin
            e = sb.pop_front();
            if (o_instr !== e.instr || o_pc !== e.pc || o_instr_illegal !== e.illegal)
                $display("FAIL post_reset_instr: got %h@%h ill=%b, required %h@%h ill=%b",
                         o_instr, o_pc, o_instr_illegal, e.instr, e.pc, e.illegal);
            else n_pass++;
        end
        n_total++;
        if (sb.size() != 0) $display("FAIL sb_drain: %0d left, required 0", sb.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_decode_stall();
        test_redirect_in_wait();
        test_redirect_with_rsp();
        test_redirect_in_hold();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0, sets the PC value loaded on reset.
REQ-002 Port i_clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 Port i_rst  input  1  is the reset: synchronous, active-high.
REQ-004 Port o_mem_req_valid  output  1  is the instruction-memory read request valid.
REQ-005 Port i_mem_req_ready  input  1  means memory accepts the request this cycle.
REQ-006 Port o_mem_addr  output  64  is the fetch address, always equal to the current PC.
REQ-007 Port i_mem_rsp_valid  input  1  means the read data is valid this cycle.
REQ-008 Port i_mem_rsp_data  input  32  is the instruction word returned by memory.
REQ-009 Port o_instr_valid  output  1  means an instruction is presented to decode.
REQ-010 Port i_instr_ready  input  1  means decode accepts the instruction this cycle.
REQ-011 Port o_instr  output  32  is the fetched instruction; bits [6:0] feed the decoder opcode input.
REQ-012 Port o_pc  output  64  is the PC of o_instr.
REQ-013 Port i_redirect  input  1  is a branch/jump redirect strobe.
REQ-014 Port i_redirect_pc  input  64  is the redirect target; bits [1:0] are forced to zero internally.
REQ-015 Port o_instr_illegal  output  1  flags an unsupported opcode in o_instr (see Configuration).

Function
REQ-016 The FSM SHALL have states IDLE, REQ, WAIT and HOLD; at most one memory request is outstanding, and responses arrive in order.
REQ-017 IDLE SHALL go to REQ on the first cycle after reset is released.
REQ-018 REQ SHALL drive o_mem_req_valid=1; on i_mem_req_ready=1 it goes to WAIT; o_mem_addr stays stable while valid and not ready, except on redirect.
REQ-019 WAIT on i_mem_rsp_valid=1 (not squashed) SHALL register data and PC into the output buffer, set o_instr_valid=1 next cycle, PC<=PC+4 (wraps modulo 2^64), and go to HOLD.
REQ-020 HOLD SHALL keep o_instr, o_pc and o_instr_valid stable until i_instr_ready=1, then clear o_instr_valid and go to REQ; minimum cost is 3 cycles per instruction.
REQ-021 i_redirect SHALL take priority over every other event: PC<=i_redirect_pc, o_instr_valid<=0 next cycle.
REQ-022 Redirect in IDLE, REQ without handshake, or HOLD SHALL go to REQ.
REQ-023 Redirect in REQ with a same-cycle handshake, or in WAIT without a response, SHALL set the squash flag and go to or stay in WAIT.
REQ-024 Redirect in WAIT with a same-cycle response SHALL discard the data and go to REQ with squash clear.
REQ-025 A response arriving while squash=1 SHALL be discarded, SHALL clear squash, and the FSM SHALL go to REQ with the redirected PC.
REQ-026 i_mem_rsp_valid outside WAIT SHALL be ignored.

Reset
REQ-027 On i_rst=1 at a clock edge: state<=IDLE, PC<=RESET_PC, squash<=0, o_mem_req_valid=0, o_instr_valid=0, o_instr=0, o_pc=0, o_instr_illegal=0.
REQ-028 Reset mid-transaction SHALL abandon any pending response; responses after reset, before the first new request, SHALL be ignored.

Configuration
REQ-029 With FETCH_OPCODE_CHECK_EN defined, o_instr_illegal SHALL be 1, registered with o_instr, when o_instr[6:0] is not one of LOAD, OP_IMM, JALR, OP_IMM_32, STORE, OP, OP_32, BRANCH, JAL, AUIPC, LUI.
REQ-030 Without FETCH_OPCODE_CHECK_EN, o_instr_illegal SHALL be tied to 0 and no check logic is synthesized.

Structure
REQ-031 The opcode constants (7-bit) and the fetch FSM state enum SHALL live in the shared package, and the decoder SHALL use the same opcode constants.
REQ-032 The opcode legality check SHALL be a sub-module, opcode_check, instantiated only under FETCH_OPCODE_CHECK_EN.

Verification
REQ-033 Reset release, memory always ready, 1-cycle response, decode always ready -> addresses 0x0, 0x4, 0x8 requested; o_pc matches each address.
REQ-034 Decode holds i_instr_ready=0 for 5 cycles with o_instr=0x00500093 -> o_instr and o_pc stable, no new request issued.
REQ-035 Redirect to 0x1002 while in WAIT, then response 0xDEADBEEF -> data dropped, next request at 0x1000.
REQ-036 Redirect coincident with response in WAIT -> no o_instr_valid; next request at the target.
REQ-037 FETCH_OPCODE_CHECK_EN defined, fetched word 0x0000007F -> o_instr_illegal=1; word 0x00000013 -> 0.
REQ-038 i_rst asserted in WAIT, late response arrives -> response ignored, first request after reset at RESET_PC.
